// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder.
// Contents: decoder state enum, frame marker/response bytes, frame length
// constants.
// Build option: UART_CMD_CHECKSUM_EN adds the trailing CHK byte and the CHK
// state; without it frames are 6 bytes and the CHK state does not exist.
package uart_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam int unsigned DATA_BYTES = 4;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 7;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_WRITE,
    ST_RESP,
    ST_WAIT_DONE
  } state_e;
`else
  localparam int unsigned FRAME_LEN = 6;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RESP,
    ST_WAIT_DONE
  } state_e;
`endif

  localparam logic [1:0] LAST_DATA_IDX = 2'(DATA_BYTES - 1);

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter for the UART command decoder.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   clr       - clear the count (has priority over expiry)
//   en        - count this cycle
//   expired   - one-cycle pulse after CYCLES consecutive enabled cycles
//               without a clear; the counter restarts from zero
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: assembles frames A5, ADDR, D3..D0 [, CHK]
// from the UART receiver, issues one register write per valid frame and
// answers with an ACK/NAK byte through the UART transmitter.
// Build option: UART_CMD_CHECKSUM_EN enables the CHK byte and NAK responses.
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   rx_data, rx_rec_flag  - received byte and sticky byte-available flag
//   rx_clr                - one-cycle pulse consuming the current byte
//   tx_data, tx_start     - response byte and one-cycle transmit request
//   tx_idle, tx_done      - transmitter ready / byte-sent pulse
//   reg_addr, reg_wdata   - register write address/data (held until next write)
//   reg_we                - one-cycle register write strobe
//   frame_err             - one-cycle pulse on timeout or checksum failure
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned clock_freq = 100_000_000,
  parameter int unsigned timeout_ms = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rec_flag,
  output logic        rx_clr,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_idle,
  input  logic        tx_done,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        frame_err
);

  localparam int unsigned TIMEOUT_CYCLES = clock_freq / 1000 * timeout_ms;

  state_e      state_q, state_d;
  logic        rx_clr_q, rx_clr_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  resp_q, resp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        frame_err_q, frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic accept;
  logic in_frame;
  logic tmo_expired;

  // rx_clr_q doubles as the blanking flag: the receiver still shows the
  // consumed byte during the cycle rx_clr is high.
  assign accept   = rx_rec_flag && !rx_clr_q;
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA)
`ifdef UART_CMD_CHECKSUM_EN
                 || (state_q == ST_CHK)
`endif
                 ;

  uart_cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_frame || accept),
    .en      (in_frame),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    rx_clr_d    = 1'b0;
    idx_d       = idx_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    resp_d      = resp_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      ST_HUNT: begin
        if (accept) begin
          rx_clr_d = 1'b1;
          if (rx_data == HDR_BYTE) begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (accept) begin
          rx_clr_d = 1'b1;
          addr_d   = rx_data;
          idx_d    = '0;
          state_d  = ST_DATA;
`ifdef UART_CMD_CHECKSUM_EN
          sum_d    = rx_data;
`endif
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
      ST_DATA: begin
        if (accept) begin
          rx_clr_d = 1'b1;
          shift_d  = {shift_q[23:0], rx_data};
          idx_d    = idx_q + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
          sum_d    = sum_q + rx_data;
          if (idx_q == LAST_DATA_IDX) begin
            state_d = ST_CHK;
          end
`else
          if (idx_q == LAST_DATA_IDX) begin
            resp_d  = ACK_BYTE;
            state_d = ST_WRITE;
          end
`endif
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          rx_clr_d = 1'b1;
          if (rx_data == sum_q) begin
            resp_d  = ACK_BYTE;
            state_d = ST_WRITE;
          end else begin
            frame_err_d = 1'b1;
            resp_d      = NAK_BYTE;
            state_d     = ST_RESP;
          end
        end else if (tmo_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_HUNT;
        end
      end
`endif
      ST_WRITE: begin
        reg_we_d    = 1'b1;
        reg_addr_d  = addr_q;
        reg_wdata_d = shift_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (tx_idle) begin
          tx_data_d  = resp_q;
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      rx_clr_q    <= 1'b0;
      idx_q       <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      resp_q      <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_clr_q    <= rx_clr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      resp_q      <= resp_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      frame_err_q <= frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rx_clr    = rx_clr_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder. Scaled-down clock
// parameters give a 1000-cycle inter-byte timeout. Works in both the default
// build and with UART_CMD_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned TMO_MS = 1;
  localparam int unsigned TMO    = CLK_HZ / 1000 * TMO_MS;  // 1000 cycles
  localparam int unsigned TX_LEN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rec_flag = 1'b0;
  logic        rx_clr;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_idle;
  logic        tx_done;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        frame_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  uart_cmd_decoder #(
    .clock_freq (CLK_HZ),
    .timeout_ms (TMO_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rec_flag (rx_rec_flag),
    .rx_clr      (rx_clr),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_idle     (tx_idle),
    .tx_done     (tx_done),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse event log, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned n_clr = 0, n_we = 0, n_start = 0, n_done = 0, n_err = 0;
  int unsigned cyc_clr = 0, cyc_we = 0, cyc_start = 0, cyc_err = 0;
  logic [7:0]  we_addr_log [16];
  logic [31:0] we_data_log [16];
  logic [7:0]  start_data = 8'h00;
  logic [7:0]  done_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_clr) begin
      n_clr   <= n_clr + 1;
      cyc_clr <= cyc;
    end
    if (reg_we) begin
      n_we   <= n_we + 1;
      cyc_we <= cyc;
      if (n_we < 16) begin
        we_addr_log[n_we] <= reg_addr;
        we_data_log[n_we] <= reg_wdata;
      end
    end
    if (tx_start) begin
      n_start    <= n_start + 1;
      cyc_start  <= cyc;
      start_data <= tx_data;
    end
    if (tx_done) begin
      n_done    <= n_done + 1;
      done_data <= tx_data;
    end
    if (frame_err) begin
      n_err   <= n_err + 1;
      cyc_err <= cyc;
    end
  end

  // Transmitter model: busy for TX_LEN+1 cycles after tx_start, then tx_done.
  logic        hold_tx = 1'b0;
  logic        sending = 1'b0;
  int unsigned tx_cnt = 0;

  initial begin
    tx_idle = 1'b1;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (sending) begin
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          sending = 1'b0;
        end else begin
          tx_cnt = tx_cnt - 1;
        end
      end else if (tx_start) begin
        sending = 1'b1;
        tx_cnt  = TX_LEN;
      end
      tx_idle = !sending && !hold_tx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 50000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte; the flag drops one cycle after rx_clr, like the receiver.
  task automatic send_byte(input logic [7:0] b, input int unsigned bound);
    int unsigned c0;
    int unsigned k;
    c0 = n_clr;
    k  = 0;
    rx_data     = b;
    rx_rec_flag = 1'b1;
    while (n_clr == c0 && k < bound) begin
      tick();
      k++;
    end
    check("byte_accepted", 32'(n_clr - c0), 32'd1);
    rx_rec_flag = 1'b0;
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [31:0] d);
    return a + d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction
`endif

  task automatic send_payload(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    send_byte(addr, 20);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[31:24], 20);
      d = d << 8;
    end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(frame_sum(addr, data), 20);
`endif
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data);
    send_byte(8'hA5, 20);
    send_payload(addr, data);
  endtask

  task automatic wait_done(input int unsigned target, input string tag);
    int unsigned k;
    k = 0;
    while (n_done < target && k < 400) begin
      tick();
      k++;
    end
    check(tag, n_done, target);
  endtask

  int unsigned we0, st0, er0, cl0, dn0;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_rx_clr",    32'(rx_clr),    32'd0);
    check("rst_tx_start",  32'(tx_start),  32'd0);
    check("rst_tx_data",   32'(tx_data),   32'h00);
    check("rst_reg_we",    32'(reg_we),    32'd0);
    check("rst_reg_addr",  32'(reg_addr),  32'h00);
    check("rst_reg_wdata", reg_wdata,      32'h0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick();

    // Valid frame A5 10 12 34 56 78 [24]
    we0 = n_we; st0 = n_start; er0 = n_err; dn0 = n_done;
    send_frame(8'h10, 32'h12345678);
    wait_done(dn0 + 1, "f1_done");
    check("f1_we_count",    n_we - we0,       32'd1);
    check("f1_addr",        32'(we_addr_log[we0]), 32'h10);
    check("f1_wdata",       we_data_log[we0], 32'h12345678);
    check("f1_start_count", n_start - st0,    32'd1);
    check("f1_ack",         32'(start_data),  32'h06);
    check("f1_ack_held",    32'(done_data),   32'h06);
    check("f1_we_latency",  cyc_we - cyc_clr,    32'd1);
    check("f1_tx_latency",  cyc_start - cyc_clr, 32'd2);
    check("f1_no_err",      n_err - er0,      32'd0);
    check("f1_addr_hold",   32'(reg_addr),    32'h10);
    check("f1_wdata_hold",  reg_wdata,        32'h12345678);

`ifdef UART_CMD_CHECKSUM_EN
    // Same frame with CHK = 00 -> NAK, frame_err, no write
    we0 = n_we; st0 = n_start; er0 = n_err; dn0 = n_done;
    send_byte(8'hA5, 20);
    send_byte(8'h10, 20);
    send_byte(8'h12, 20);
    send_byte(8'h34, 20);
    send_byte(8'h56, 20);
    send_byte(8'h78, 20);
    send_byte(8'h00, 20);
    wait_done(dn0 + 1, "bad_done");
    check("bad_no_we",      n_we - we0,      32'd0);
    check("bad_err_count",  n_err - er0,     32'd1);
    check("bad_nak",        32'(start_data), 32'h15);
    check("bad_addr_hold",  32'(reg_addr),   32'h10);
`endif

    // Junk before a frame is dropped silently
    we0 = n_we; er0 = n_err; cl0 = n_clr; dn0 = n_done;
    send_byte(8'h00, 20);
    send_byte(8'hFF, 20);
    send_byte(8'h33, 20);
    repeat (4) tick();
    check("junk_clr_count", n_clr - cl0, 32'd3);
    check("junk_no_err",    n_err - er0, 32'd0);
    check("junk_no_we",     n_we - we0,  32'd0);
    send_frame(8'h22, 32'hDEADBEEF);
    wait_done(dn0 + 1, "junk_done");
    check("junk_we_count", n_we - we0, 32'd1);
    check("junk_addr",     32'(we_addr_log[we0]), 32'h22);
    check("junk_wdata",    we_data_log[we0], 32'hDEADBEEF);

    // A5 inside a frame is payload, not a resync
    we0 = n_we; dn0 = n_done;
    send_frame(8'hA5, 32'hA5A5A5A5);
    wait_done(dn0 + 1, "a5_done");
    check("a5_addr",  32'(we_addr_log[we0]), 32'hA5);
    check("a5_wdata", we_data_log[we0], 32'hA5A5A5A5);

    // Timeout after A5 10 12
    st0 = n_start; er0 = n_err; we0 = n_we;
    send_byte(8'hA5, 20);
    send_byte(8'h10, 20);
    send_byte(8'h12, 20);
    for (int k = 0; k < int'(TMO) + 50 && n_err == er0; k++) tick();
    check("tmo_err_count", n_err - er0,       32'd1);
    check("tmo_latency",   cyc_err - cyc_clr, TMO);
    repeat (20) tick();
    check("tmo_no_start",  n_start - st0,     32'd0);
    check("tmo_no_we",     n_we - we0,        32'd0);
    dn0 = n_done;
    send_frame(8'h33, 32'h01020304);
    wait_done(dn0 + 1, "tmo_next_done");
    check("tmo_next_addr",  32'(we_addr_log[we0]), 32'h33);
    check("tmo_next_wdata", we_data_log[we0], 32'h01020304);

    // Gap just short of the limit is not a timeout
    er0 = n_err; we0 = n_we; dn0 = n_done;
    send_byte(8'hA5, 20);
    send_byte(8'h3C, 20);
    repeat (TMO - 10) tick();
    send_byte(8'h00, 20);
    send_byte(8'h00, 20);
    send_byte(8'h00, 20);
    send_byte(8'h07, 20);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h43, 20);
`endif
    wait_done(dn0 + 1, "gap_done");
    check("gap_no_err", n_err - er0, 32'd0);
    check("gap_addr",   32'(we_addr_log[we0]), 32'h3C);
    check("gap_wdata",  we_data_log[we0], 32'h00000007);

    // Reset after A5 10
    send_byte(8'hA5, 20);
    send_byte(8'h10, 20);
    rst = 1'b1;
    tick();
    check("mid_rst_tx_data",   32'(tx_data),   32'h00);
    check("mid_rst_reg_addr",  32'(reg_addr),  32'h00);
    check("mid_rst_reg_wdata", reg_wdata,      32'h0);
    check("mid_rst_rx_clr",    32'(rx_clr),    32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick();
    we0 = n_we; dn0 = n_done;
    send_frame(8'h44, 32'hCAFEF00D);
    wait_done(dn0 + 1, "rst_next_done");
    check("rst_next_addr",  32'(we_addr_log[we0]), 32'h44);
    check("rst_next_wdata", we_data_log[we0], 32'hCAFEF00D);

    // Back-to-back frames with the transmitter busy
    we0 = n_we; st0 = n_start; dn0 = n_done;
    hold_tx = 1'b1;
    repeat (2) tick();
    send_frame(8'h55, 32'h11111111);
    repeat (5) tick();
    check("b2b_first_we",    n_we - we0,    32'd1);
    check("b2b_start_held",  n_start - st0, 32'd0);
    cl0 = n_clr;
    rx_data     = 8'hA5;
    rx_rec_flag = 1'b1;
    repeat (170) tick();
    check("b2b_byte_pending", n_clr - cl0, 32'd0);
    hold_tx = 1'b0;
    for (int k = 0; k < 60 && n_clr == cl0; k++) tick();
    check("b2b_byte_taken",  n_clr - cl0,  32'd1);
    check("b2b_after_done",  n_done - dn0, 32'd1);
    rx_rec_flag = 1'b0;
    send_payload(8'h66, 32'h22222222);
    wait_done(dn0 + 2, "b2b_done");
    check("b2b_we_count",    n_we - we0,    32'd2);
    check("b2b_start_count", n_start - st0, 32'd2);
    check("b2b_addr0",  32'(we_addr_log[we0]),     32'h55);
    check("b2b_wdata0", we_data_log[we0],          32'h11111111);
    check("b2b_addr1",  32'(we_addr_log[we0 + 1]), 32'h66);
    check("b2b_wdata1", we_data_log[we0 + 1],      32'h22222222);
    check("b2b_ack",    32'(start_data),           32'h06);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
